// File: rtl/tx_pkg.sv
// ---------------------------------------------------------------------------
// tx_pkg
// Shared definitions for the transmit frame scheduler:
//   state_t      - scheduler FSM states (IDLE, LOAD, SEND)
//   FRAME_BYTES  - transmit buffer capacity in bytes (128-bit buffer)
//   LEN_W        - width of the frame length field (holds 0..16)
//   frame_full() - true when a byte count has reached buffer capacity
// ---------------------------------------------------------------------------
package tx_pkg;

  localparam int FRAME_BYTES = 16;
  localparam int LEN_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  function automatic logic frame_full(input logic [LEN_W-1:0] count);
    return count == LEN_W'(FRAME_BYTES);
  endfunction

endpackage

// File: rtl/tx_frame_sched_if.sv
// ---------------------------------------------------------------------------
// tx_frame_sched_if
// Bundles every non-clock/reset signal of the scheduler.
//   Requester side : req_valid[1:0], req_last[1:0], req_data0, req_data1 (in)
//                    req_ready[1:0] (out)
//   Buffer side    : buf_en, buf_data (out)
//   Transmitter    : frame_go, frame_len, frame_src (out), tx_done (in)
//   Status         : busy (out)
// Modport master is the scheduler; modport slave is its environment.
// ---------------------------------------------------------------------------
interface tx_frame_sched_if;
  import tx_pkg::*;

  logic [1:0]       req_valid;
  logic [1:0]       req_last;
  logic [7:0]       req_data0;
  logic [7:0]       req_data1;
  logic [1:0]       req_ready;
  logic             buf_en;
  logic [7:0]       buf_data;
  logic             frame_go;
  logic [LEN_W-1:0] frame_len;
  logic             frame_src;
  logic             tx_done;
  logic             busy;

  modport master (
    input  req_valid, req_last, req_data0, req_data1, tx_done,
    output req_ready, buf_en, buf_data, frame_go, frame_len, frame_src, busy
  );

  modport slave (
    output req_valid, req_last, req_data0, req_data1, tx_done,
    input  req_ready, buf_en, buf_data, frame_go, frame_len, frame_src, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin picker, purely combinational.
//   req[1:0]    - request vector
//   last_served - index of the requester that owned the previous frame
//   grant       - index of the winning requester (meaningful when |req)
// The last-served state is held by the caller.
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       grant
);

  // With both requesting, the one not served last wins; otherwise the
  // single requester wins. No request defaults to index 0.
  always_comb begin
    grant = 1'b0;
    unique case (req)
      2'b11:   grant = ~last_served;
      2'b10:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/tx_frame_sched.sv
// ---------------------------------------------------------------------------
// tx_frame_sched
// Transmit frame scheduler in front of the 16-byte transmit shift buffer.
// Picks one of two byte-stream requesters round-robin, streams its bytes into
// the buffer, closes the frame on the packet's last byte or on a full buffer,
// then holds frame_go until the transmitter pulses tx_done.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - tx_frame_sched_if.master (requester, buffer, tx, status)
// ---------------------------------------------------------------------------
module tx_frame_sched
  import tx_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  tx_frame_sched_if.master bus
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic             src_q, src_d;
  logic             last_q, last_d;
  logic             buf_en_q, buf_en_d;
  logic [7:0]       buf_data_q, buf_data_d;

  logic             grant;
  logic             cur_valid;
  logic             cur_last;
  logic [7:0]       cur_data;
  logic [LEN_W-1:0] count_inc;

  // last_q resets to 1 so requester 0 wins the first contested grant.
  rr_arb2 u_arb (
    .req         (bus.req_valid),
    .last_served (last_q),
    .grant       (grant)
  );

  assign cur_valid = bus.req_valid[src_q];
  assign cur_last  = bus.req_last[src_q];
  assign cur_data  = src_q ? bus.req_data1 : bus.req_data0;
  assign count_inc = count_q + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      src_q      <= 1'b0;
      last_q     <= 1'b1;
      buf_en_q   <= 1'b0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      src_q      <= src_d;
      last_q     <= last_d;
      buf_en_q   <= buf_en_d;
      buf_data_q <= buf_data_d;
    end
  end

  // Next-state logic. buf_en is a one-cycle strobe per accepted byte; the
  // data register simply holds between strobes.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    src_d      = src_q;
    last_d     = last_q;
    buf_en_d   = 1'b0;
    buf_data_d = buf_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          src_d   = grant;
          count_d = '0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // ready is always high for the owner here, so valid alone is a transfer
        if (cur_valid) begin
          count_d    = count_inc;
          buf_en_d   = 1'b1;
          buf_data_d = cur_data;
          if (cur_last || frame_full(count_inc)) begin
            state_d = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        if (bus.tx_done) begin
          last_d  = src_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // req_ready depends only on state and owner, never on req_valid.
  always_comb begin
    bus.req_ready = 2'b00;
    if (state_q == ST_LOAD) begin
      bus.req_ready = src_q ? 2'b10 : 2'b01;
    end
  end

  assign bus.buf_en    = buf_en_q;
  assign bus.buf_data  = buf_data_q;
  assign bus.frame_go  = (state_q == ST_SEND);
  assign bus.frame_len = count_q;
  assign bus.frame_src = src_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/tx_frame_sched.md
# tx_frame_sched

Transmit-side frame scheduler that sits in front of the 16-byte transmit shift buffer. It arbitrates round-robin between two byte-stream requesters and streams the granted requester's bytes into the buffer through its shift-enable/data inputs. It closes a frame on the requester's last byte or when the buffer is full, then holds a send request to the line transmitter until the transmitter reports completion. Only one frame is in flight at a time.

## Interface
- FRAME_BYTES, 16, buffer capacity in bytes; must be 16 to match the 128-bit buffer.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester byte valid.
- req_last  in  2  per-requester marker: the current byte ends its packet.
- req_data0  in  8  requester 0 byte.
- req_data1  in  8  requester 1 byte.
- req_ready  out  2  per-requester accept; at most one bit high.
- buf_en  out  1  shift enable to the transmit buffer, registered.
- buf_data  out  8  byte to the transmit buffer, registered.
- frame_go  out  1  frame ready to send; held until tx_done.
- frame_len  out  5  bytes in the current frame, 1..16.
- frame_src  out  1  requester that owns the current frame.
- tx_done  in  1  single-cycle pulse from the transmitter: frame sent, buffer may be refilled.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, LOAD, SEND. Reset state is IDLE.
- IDLE: if any req_valid is set, grant one requester, latch frame_src, clear the byte count, and go to LOAD. If none is set, stay in IDLE.
  - Grant rule: round-robin. The requester not served last wins when both are valid. After reset, requester 0 has priority.
- LOAD: req_ready[frame_src] = 1, and the other bit is 0.
  - A transfer occurs on a cycle where valid and ready are both high.
  - Each transfer increments the count and writes the byte to buf_data/buf_en on the next cycle.
  - Leave to SEND on a transfer with req_last, or on the transfer that makes count = FRAME_BYTES.
  - Idle cycles without valid do not end the frame.
- SEND: frame_go = 1 and frame_len = count, stable. req_ready = 0.
  - On tx_done, go to IDLE and record frame_src as last served.
- A 16-byte frame without last: the remaining bytes of that packet are re-arbitrated as a new frame. The other requester may win it.
- tx_done is ignored in IDLE and LOAD.
- The count never exceeds 16. frame_len width is 5 bits, so 16 is representable.

## Timing
- Reset values: req_ready=0, buf_en=0, buf_data=0, frame_go=0, frame_len=0, frame_src=0, busy=0.
- Grant latency: the request is seen in IDLE at edge N. State is LOAD after edge N, and req_ready is high during cycle N+1.
- Byte latency: a transfer at edge N produces buf_en=1 with that byte during cycle N+1, for exactly one cycle per byte.
- The final transfer at edge N puts the FSM in SEND during N+1.
  - frame_go rises in the same cycle as the last buf_en pulse.
  - The buffer therefore holds all bytes by edge N+1.
- tx_done sampled at edge M: frame_go is low from M, and the state is IDLE.
  - The earliest next grant is at edge M+1.
- req_ready is a combinational function of state and frame_src only. It has no dependence on req_valid.
- Reset asserted mid-LOAD or mid-SEND: all outputs drop to reset values immediately. Partial frames are discarded, and the buffer contents are don't-care.

## Structure
- Package tx_pkg holds:
  - the FSM state enum (IDLE, LOAD, SEND);
  - the FRAME_BYTES constant;
  - the frame-length width constant (5).
- Sub-module rr_arb2: a two-input round-robin picker.
  - Inputs: request vector and last-served bit.
  - Output: grant index.
  - Combinational. The last-served register lives in the scheduler.

## Test plan
- Reset, then only req 0 sends 3 bytes (0xA1, 0xA2, 0xA3 with last) -> three buf_en pulses carrying those bytes, then frame_go=1 with frame_len=3 and frame_src=0. A tx_done pulse returns the block to IDLE with busy=0.
- Both requesters hold valid continuously with 2-byte packets -> frames alternate by source 0, 1, 0, 1, and req_ready is never high for both.
- Req 1 sends 20 bytes (0x00..0x13, last on 0x13) -> first frame has frame_len=16 with bytes 0x00..0x0F. After tx_done, the second frame has frame_len=4 with bytes 0x10..0x13.
- req_valid gaps mid-packet (valid low for 3 cycles between bytes) -> there is no buf_en during the gaps, and frame_len counts only transferred bytes.
- tx_done pulsed during LOAD and during IDLE -> no state change. In SEND, a tx_done delayed by 10 cycles keeps frame_go and frame_len stable for all 10 cycles.
- rst_n asserted during LOAD after 5 bytes -> outputs go to reset values asynchronously. After release, req 0 is granted first and the next frame's frame_len counts from 1.
